// File: rtl/ram_port_arbiter.sv
// Round-robin burst arbiter sharing one RAM port between two requesters.
// Sequences one word per cycle and returns read data after the RAM's 1-cycle latency.
module ram_port_arbiter #(
    parameter int unsigned AWIDTH      = 10,
    parameter int unsigned DESIGN_SIZE = 8,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned LEN_W       = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req0,
    input  logic                          req1,
    input  logic                          we_req0,
    input  logic                          we_req1,
    input  logic [AWIDTH-1:0]             addr_req0,
    input  logic [AWIDTH-1:0]             addr_req1,
    input  logic [LEN_W-1:0]              len_req0,
    input  logic [LEN_W-1:0]              len_req1,
    output logic                          gnt0,
    output logic                          gnt1,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] wdata0,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] wdata1,
    output logic                          wdata_rdy0,
    output logic                          wdata_rdy1,
    output logic [DESIGN_SIZE*DWIDTH-1:0] rdata0,
    output logic [DESIGN_SIZE*DWIDTH-1:0] rdata1,
    output logic                          rvalid0,
    output logic                          rvalid1,
    output logic                          done0,
    output logic                          done1,
    output logic                          busy,
    output logic [AWIDTH-1:0]             ram_addr,
    output logic [DESIGN_SIZE*DWIDTH-1:0] ram_d,
    output logic [DESIGN_SIZE-1:0]        ram_we,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q
);

    localparam int unsigned WORD_W = DESIGN_SIZE * DWIDTH;
    localparam logic [AWIDTH-1:0] STRIDE = AWIDTH'(DESIGN_SIZE);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t              state;
    logic                owner;
    logic                we_q;
    logic                last_grant;
    logic [AWIDTH-1:0]   cur_addr;
    logic [LEN_W-1:0]    cnt;
    logic [WORD_W-1:0]   rdata0_q;
    logic [WORD_W-1:0]   rdata1_q;

    logic                pick1;
    logic                sel_we;
    logic [AWIDTH-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;

    // Lone requester wins; on a tie the requester not granted last time wins
    always_comb begin
        pick1    = req1 && (!req0 || !last_grant);
        sel_we   = pick1 ? we_req1   : we_req0;
        sel_addr = pick1 ? addr_req1 : addr_req0;
        sel_len  = pick1 ? len_req1  : len_req0;
    end

    assign gnt0 = !reset && (state == IDLE) && req0 && !pick1;
    assign gnt1 = !reset && (state == IDLE) && pick1;

    // Write data passes straight from the owner to the RAM in the issue cycle
    always_comb begin
        ram_d = '0;
        if (state == BURST && we_q) begin
            ram_d = owner ? wdata1 : wdata0;
        end
    end

    // Read data shows the RAM output while valid, otherwise the last returned word
    assign rdata0 = rvalid0 ? ram_q : rdata0_q;
    assign rdata1 = rvalid1 ? ram_q : rdata1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            last_grant <= 1'b1;
            cur_addr   <= '0;
            cnt        <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            wdata_rdy0 <= 1'b0;
            wdata_rdy1 <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= '0;
        end else begin
            done0   <= 1'b0;
            done1   <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (rvalid0) rdata0_q <= ram_q;
            if (rvalid1) rdata1_q <= ram_q;

            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= pick1;
                        last_grant <= pick1;
                        we_q       <= sel_we;
                        cnt        <= sel_len;
                        ram_addr   <= sel_addr;
                        cur_addr   <= sel_addr + STRIDE;
                        ram_we     <= sel_we ? '1 : '0;
                        wdata_rdy0 <= sel_we && !pick1;
                        wdata_rdy1 <= sel_we && pick1;
                        busy       <= 1'b1;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    // A read issued this cycle returns data next cycle
                    rvalid0 <= !we_q && !owner;
                    rvalid1 <= !we_q && owner;
                    if (cnt == '0) begin
                        ram_we     <= '0;
                        wdata_rdy0 <= 1'b0;
                        wdata_rdy1 <= 1'b0;
                        done0      <= !owner;
                        done1      <= owner;
                        state      <= DRAIN;
                    end else begin
                        cnt      <= cnt - LEN_W'(1);
                        ram_addr <= cur_addr;
                        cur_addr <= cur_addr + STRIDE;
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: timeline model of expected port activity plus directed scenarios.
module tb_ram_port_arbiter;

    localparam int unsigned SL = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we_req0, we_req1;
    logic [9:0]  addr_req0, addr_req1;
    logic [5:0]  len_req0, len_req1;
    logic        gnt0, gnt1, wdata_rdy0, wdata_rdy1, rvalid0, rvalid1, done0, done1, busy;
    logic [63:0] wdata0, wdata1, rdata0, rdata1, ram_d, ram_q;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_we;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign wdata0 = {32'hC0DE_0000, 32'(cyc)};
    assign wdata1 = {32'hBEEF_0000, 32'(cyc)};

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we_req0(we_req0), .we_req1(we_req1),
        .addr_req0(addr_req0), .addr_req1(addr_req1),
        .len_req0(len_req0), .len_req1(len_req1),
        .gnt0(gnt0), .gnt1(gnt1),
        .wdata0(wdata0), .wdata1(wdata1),
        .wdata_rdy0(wdata_rdy0), .wdata_rdy1(wdata_rdy1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .done0(done0), .done1(done1), .busy(busy),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    function automatic logic [63:0] init_word(input int i);
        return {32'h5A5A_0000 | 32'(i), ~32'(i)};
    endfunction

    // Environment RAM: registered read, read-before-write
    logic [63:0] ram [128];
    initial for (int i = 0; i < 128; i++) ram[i] = init_word(i);
    always @(posedge clk) begin
        if (ram_we == 8'hFF) ram[ram_addr[9:3]] <= ram_d;
        ram_q <= ram[ram_addr[9:3]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: each grant books its word issues, read returns and done pulse on a timeline
    bit          s_issue [SL];
    bit          s_we    [SL];
    bit          s_own   [SL];
    bit          s_rv    [SL];
    bit          s_done  [SL];
    bit          s_busy  [SL];
    logic [9:0]  s_addr  [SL];
    logic [9:0]  s_rvaddr[SL];
    logic [63:0] m_mem   [128];
    logic [63:0] m_rd    [2];
    logic [9:0]  m_addr_hold = '0;
    int          m_idle_at = 0;
    bit          m_lg = 1'b1;
    bit          m_en = 1'b0;

    initial for (int i = 0; i < 128; i++) m_mem[i] = init_word(i);

    always @(negedge clk) begin
        int k, n, j;
        bit e_wr, e_g0, e_g1, o, w;
        logic [63:0] e_d;
        logic [9:0]  a;
        k    = cyc % SL;
        e_wr = s_issue[k] && s_we[k];
        e_d  = e_wr ? (s_own[k] ? wdata1 : wdata0) : 64'h0;
        if (s_issue[k]) m_addr_hold = s_addr[k];
        if (s_rv[k]) m_rd[s_own[k]] = m_mem[s_rvaddr[k][9:3]];
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!reset && cyc >= m_idle_at) begin
            if (req0 && (!req1 || m_lg)) e_g0 = 1'b1;
            else if (req1)               e_g1 = 1'b1;
        end
        if (m_en) begin
            chk("gnt0", 64'(gnt0), 64'(e_g0));
            chk("gnt1", 64'(gnt1), 64'(e_g1));
            chk("ram_addr", 64'(ram_addr), 64'(m_addr_hold));
            chk("ram_we", 64'(ram_we), e_wr ? 64'hFF : 64'h0);
            chk("ram_d", ram_d, e_d);
            chk("wdata_rdy0", 64'(wdata_rdy0), 64'(e_wr && !s_own[k]));
            chk("wdata_rdy1", 64'(wdata_rdy1), 64'(e_wr && s_own[k]));
            chk("rvalid0", 64'(rvalid0), 64'(s_rv[k] && !s_own[k]));
            chk("rvalid1", 64'(rvalid1), 64'(s_rv[k] && s_own[k]));
            chk("rdata0", rdata0, m_rd[0]);
            chk("rdata1", rdata1, m_rd[1]);
            chk("done0", 64'(done0), 64'(s_done[k] && !s_own[k]));
            chk("done1", 64'(done1), 64'(s_done[k] && s_own[k]));
            chk("busy", 64'(busy), 64'(s_busy[k]));
        end
        if (e_wr) m_mem[s_addr[k][9:3]] = e_d;
        s_issue[k] = 0; s_we[k] = 0; s_rv[k] = 0; s_done[k] = 0; s_busy[k] = 0;
        if (e_g0 || e_g1) begin
            o = e_g1;
            w = o ? we_req1 : we_req0;
            a = o ? addr_req1 : addr_req0;
            n = int'(o ? len_req1 : len_req0) + 1;
            for (int i = 0; i < n; i++) begin
                j = (cyc + 1 + i) % SL;
                s_issue[j] = 1; s_we[j] = w; s_own[j] = o; s_busy[j] = 1;
                s_addr[j]  = 10'(int'(a) + 8 * i);
                if (!w) begin
                    j = (cyc + 2 + i) % SL;
                    s_rv[j] = 1; s_own[j] = o; s_rvaddr[j] = 10'(int'(a) + 8 * i);
                end
            end
            j = (cyc + n + 1) % SL;
            s_done[j] = 1; s_busy[j] = 1; s_own[j] = o;
            m_idle_at = cyc + n + 2;
            m_lg = o;
        end
        if (reset) begin
            for (int i = 0; i < int'(SL); i++) begin
                s_issue[i] = 0; s_we[i] = 0; s_rv[i] = 0; s_done[i] = 0; s_busy[i] = 0;
            end
            m_idle_at   = cyc + 1;
            m_lg        = 1'b1;
            m_addr_hold = '0;
            m_rd[0]     = '0;
            m_rd[1]     = '0;
            m_en        = 1'b1;
        end
    end

    // Raise a request, wait for its grant, drop it; returns the grant cycle
    task automatic do_req(input bit id, input bit w, input logic [9:0] a, input logic [5:0] l,
                          output int g);
        bit got = 0;
        g = -1;
        if (id) begin req1 = 1; we_req1 = w; addr_req1 = a; len_req1 = l; end
        else    begin req0 = 1; we_req0 = w; addr_req0 = a; len_req0 = l; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) begin got = 1; g = cyc; end
        end
        if (!got) chk("gnt_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        if (id) req1 = 0; else req0 = 0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) chk("idle_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int g, gw, gr, nb, nd, ng;
        int gid[4];
        int gc[4];
        logic [9:0] wa[4];
        wa[0] = 10'h010; wa[1] = 10'h018; wa[2] = 10'h020; wa[3] = 10'h028;

        // Reset with both requesting: quiet outputs, then requester 0 wins
        reset = 1; req0 = 1; req1 = 1; we_req0 = 0; we_req1 = 0;
        addr_req0 = 10'h000; addr_req1 = 10'h040; len_req0 = 0; len_req1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 64'(gnt0), 64'(0));
        chk("rst_gnt1", 64'(gnt1), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ram_we", 64'(ram_we), 64'h0);
        chk("rst_rvalid1", 64'(rvalid1), 64'(0));
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("first_gnt0", 64'(gnt0), 64'(1));
        chk("first_gnt1", 64'(gnt1), 64'(0));
        @(posedge clk); #1 req0 = 0;
        do_req(1, 0, 10'h040, 0, g);
        wait_idle();

        // 4-word write from requester 0
        do_req(0, 1, 10'h010, 3, gw);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("wr_addr", 64'(ram_addr), 64'(wa[i]));
                chk("wr_we", 64'(ram_we), 64'hFF);
                chk("wr_rdy0", 64'(wdata_rdy0), 64'(1));
            end
            if (i == 4) chk("wr_done0", 64'(done0), 64'(1));
            if (busy) nb++;
        end
        chk("wr_busy_cycles", 64'(nb), 64'(5));
        wait_idle();

        // 2-word read back by requester 1
        do_req(1, 0, 10'h010, 1, gr);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_rvalid0", 64'(rvalid0), 64'(0));
            chk("rd_rvalid1", 64'(rvalid1), 64'(i == 1 || i == 2));
            if (i == 1) chk("rd_word0", rdata1, {32'hC0DE_0000, 32'(gw + 1)});
            if (i == 2) begin
                chk("rd_word1", rdata1, {32'hC0DE_0000, 32'(gw + 2)});
                chk("rd_done1", 64'(done1), 64'(1));
            end
        end
        wait_idle();

        // Both held with len 0: grants alternate every 3 cycles
        we_req0 = 0; we_req1 = 0; addr_req0 = 10'h080; addr_req1 = 10'h0C0;
        len_req0 = 0; len_req1 = 0; req0 = 1; req1 = 1;
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin gid[ng] = gnt1 ? 1 : 0; gc[ng] = cyc; ng++; end
        end
        @(posedge clk); #1 req0 = 0; req1 = 0;
        chk("fair_count", 64'(ng), 64'(4));
        if (ng == 4) begin
            chk("fair_g0", 64'(gid[0]), 64'(0));
            chk("fair_g1", 64'(gid[1]), 64'(1));
            chk("fair_g2", 64'(gid[2]), 64'(0));
            chk("fair_g3", 64'(gid[3]), 64'(1));
            chk("fair_gap1", 64'(gc[1] - gc[0]), 64'(3));
            chk("fair_gap3", 64'(gc[3] - gc[2]), 64'(3));
        end
        wait_idle();

        // Burst across the top of the address space
        do_req(0, 0, 10'h3F8, 1, g);
        @(negedge clk); chk("wrap_addr0", 64'(ram_addr), 64'h3F8);
        @(negedge clk); chk("wrap_addr1", 64'(ram_addr), 64'h000);
        wait_idle();

        // Reset during the third word of an 8-word write
        do_req(0, 1, 10'h100, 7, g);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_we", 64'(ram_we), 64'h0);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_rdy0", 64'(wdata_rdy0), 64'(0));
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'(0));
        @(posedge clk); #1 req0 = 1; req1 = 1;
        @(negedge clk);
        chk("abort_gnt0", 64'(gnt0), 64'(1));
        chk("abort_gnt1", 64'(gnt1), 64'(0));
        @(posedge clk); #1 req0 = 0; req1 = 0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
